// File: rtl/perf_pkg.sv
// Shared types and default sizing for the performance-window controller.
package perf_pkg;

  localparam int PERF_CNT_W  = 32;
  localparam int PERF_FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } perf_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first.
// The first step happens on the start edge, so DIVIDEND_W edges after start the quotient is final.
module seq_divider #(
  parameter int DIVIDEND_W = 40,
  parameter int DIVISOR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(DIVIDEND_W - 1);

  logic [DIVISOR_W-1:0]  rem_q, dvs_q;
  logic [DIVIDEND_W-1:0] quo_q;
  logic [CNT_BITS-1:0]   left_q;

  logic [DIVISOR_W-1:0]  rem_in, dvs_in, rem_nxt;
  logic [DIVIDEND_W-1:0] quo_in, quo_nxt;
  logic [DIVISOR_W:0]    shifted, trial;

  // The remainder stays below the divisor, so one extra bit is enough to detect the borrow.
  always_comb begin
    rem_in  = start ? '0       : rem_q;
    quo_in  = start ? dividend : quo_q;
    dvs_in  = start ? divisor  : dvs_q;
    shifted = {rem_in, quo_in[DIVIDEND_W-1]};
    trial   = shifted - {1'b0, dvs_in};
    rem_nxt = trial[DIVISOR_W] ? shifted[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    quo_nxt = {quo_in[DIVIDEND_W-2:0], ~trial[DIVISOR_W]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      left_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q  <= rem_nxt;
        quo_q  <= quo_nxt;
        dvs_q  <= divisor;
        left_q <= LAST_STEP;
        busy   <= (LAST_STEP != '0);
        done   <= (LAST_STEP == '0);
      end else if (busy) begin
        rem_q  <= rem_nxt;
        quo_q  <= quo_nxt;
        left_q <= left_q - CNT_BITS'(1);
        if (left_q == CNT_BITS'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/perf_window_ctrl.sv
// Measurement-window controller: counts cycles/retires between start and stop,
// then produces a saturating fixed-point CPI and offers it on a valid/ready handshake.
module perf_window_ctrl
  import perf_pkg::*;
#(
  parameter int CNT_W  = PERF_CNT_W,
  parameter int FRAC_W = PERF_FRAC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             instr_retire_i,
  input  logic             res_ready_i,
  output logic             res_valid_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic [CNT_W-1:0] instrs_o,
  output logic [CNT_W-1:0] cpi_o,
  output logic             div_zero_o,
  output logic             sat_o,
  output logic             busy_o
);

  localparam int Q_W = CNT_W + FRAC_W;

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_COUNT  = 2'(COUNT);
  localparam logic [1:0] ST_DIVIDE = 2'(DIVIDE);
  localparam logic [1:0] ST_DONE   = 2'(DONE);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cycles_nxt, instrs_nxt;
  logic             cyc_ovf, ins_ovf, div_start, div_busy, div_done, q_ovf;
  logic [Q_W-1:0]   div_quo;

  // Next counter values include the stop cycle itself, so the divider is fed these directly.
  always_comb begin
    cyc_ovf    = &cycles_o;
    ins_ovf    = instr_retire_i & (&instrs_o);
    cycles_nxt = cyc_ovf ? cycles_o : cycles_o + CNT_W'(1);
    instrs_nxt = (instr_retire_i & ~ins_ovf) ? instrs_o + CNT_W'(1) : instrs_o;
    div_start  = (state_q == ST_COUNT) & stop_i & (instrs_nxt != '0);
    q_ovf      = |div_quo[Q_W-1:CNT_W];
  end

  seq_divider #(
    .DIVIDEND_W(Q_W),
    .DIVISOR_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend({cycles_nxt, {FRAC_W{1'b0}}}),
    .divisor (instrs_nxt),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cycles_o    <= '0;
      instrs_o    <= '0;
      cpi_o       <= '0;
      div_zero_o  <= 1'b0;
      sat_o       <= 1'b0;
      res_valid_o <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cycles_o   <= '0;
            instrs_o   <= '0;
            cpi_o      <= '0;
            div_zero_o <= 1'b0;
            sat_o      <= 1'b0;
            state_q    <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          cycles_o <= cycles_nxt;
          instrs_o <= instrs_nxt;
          sat_o    <= sat_o | cyc_ovf | ins_ovf;
          if (stop_i) begin
            if (instrs_nxt == '0) begin
              div_zero_o  <= 1'b1;
              cpi_o       <= '1;
              res_valid_o <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          if (div_done & ~div_busy) begin
            cpi_o       <= q_ovf ? '1 : div_quo[CNT_W-1:0];
            sat_o       <= sat_o | q_ovf;
            res_valid_o <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: doc/perf_window_ctrl.md
Name: perf_window_ctrl

Overview:
Sequencing controller for the performance-measurement path. Opens and closes a measurement window on command and counts cycles and retired instructions inside that window. At window close it runs a multi-cycle restoring divider to produce a fixed-point CPI, replacing any single-cycle division. It presents the result on a valid/ready handshake to the host/debug interface of the SIMD AES core.

Parameters:
CNT_W, 32, width of cycle/instruction counters and of cpi_o
FRAC_W, 8, fractional bits of cpi_o (format unsigned Q(CNT_W-FRAC_W).FRAC_W); must be < CNT_W

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start_i  input  1  single-cycle pulse: open measurement window
stop_i  input  1  single-cycle pulse: close measurement window
instr_retire_i  input  1  one instruction retired this cycle
res_ready_i  input  1  consumer accepts result
res_valid_o  output  1  result valid
cycles_o  output  CNT_W  cycles counted in window
instrs_o  output  CNT_W  instructions counted in window
cpi_o  output  CNT_W  cycles/instrs, fixed point
div_zero_o  output  1  window contained zero instructions
sat_o  output  1  a counter or cpi_o saturated
busy_o  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all outputs and internal registers 0 the next cycle; reset mid-operation aborts with no result.
- FSM states: IDLE, COUNT, DIVIDE, DONE.
- IDLE: start_i=1 -> clear counters and flags, go to COUNT. stop_i is ignored in IDLE. If start_i and stop_i are both high, start wins and stop is ignored.
- COUNT: every cycle cycles += 1; instrs += 1 when instr_retire_i. The cycle in which stop_i is high is counted, including its retire. start_i is ignored.
- Counters saturate at 2^CNT_W-1 and set sat_o. They never wrap.
- COUNT exit on stop_i:
  - If the final instrs = 0: go to DONE with div_zero_o=1 and cpi_o = all ones.
  - Otherwise go to DIVIDE.
- DIVIDE:
  - Dividend = cycles << FRAC_W (CNT_W+FRAC_W bits); divisor = instrs.
  - Restoring division, one quotient bit per cycle, MSB first.
  - Exactly CNT_W+FRAC_W cycles, then DONE.
  - Quotient is truncated, not rounded.
  - If the quotient is >= 2^CNT_W: cpi_o = all ones and sat_o=1.
  - start_i and stop_i are ignored.
- Latency: stop_i sampled at edge k -> res_valid_o high from cycle k+1+CNT_W+FRAC_W (k+41 at defaults). On the div-zero path, res_valid_o is high from cycle k+1.
- DONE: res_valid_o=1. cycles_o, instrs_o, cpi_o, div_zero_o and sat_o are stable until the handshake. start_i and stop_i are ignored.
- Handshake res_valid_o & res_ready_i -> next cycle IDLE and res_valid_o=0. Result outputs hold their last values until the next start_i.
- busy_o = 1 in COUNT, DIVIDE and DONE.
- res_valid_o never depends combinationally on res_ready_i.

Decomposition:
- Package perf_pkg: state enum perf_state_e {IDLE, COUNT, DIVIDE, DONE}; default constants PERF_CNT_W=32 and PERF_FRAC_W=8.
- Sub-module seq_divider:
  - Parameters: dividend width, divisor width.
  - Interface: start, dividend, divisor in; busy, done pulse, quotient out.
  - Performs the restoring division.
- perf_window_ctrl owns the FSM, the counters, saturation and the handshake.

Test Plan:
- Basic CPI at defaults: start, then 10 COUNT cycles with 4 retires, stop on the 10th -> cycles_o=10, instrs_o=4, cpi_o=0x280 (2.5), res_valid_o rises exactly 41 cycles after the stop edge.
- Zero instructions: start, 5 cycles with no retire, stop -> div_zero_o=1, cpi_o=0xFFFFFFFF, res_valid_o the cycle after stop, no DIVIDE state visited.
- Saturation with CNT_W=8, FRAC_W=4: 300 cycles, 1 retire -> cycles_o=255, sat_o=1, cpi_o=0xFF.
- Backpressure: hold res_ready_i=0 for 5 cycles in DONE -> all outputs stable each cycle. Raise ready -> IDLE next cycle, busy_o=0, res_valid_o=0.
- Reset in the middle of DIVIDE -> next cycle all outputs 0 and IDLE. A following start/stop window (6 cycles, 3 retires) gives cpi_o=0x200.
- Ignore rules: stop_i in IDLE -> no state change. start_i+stop_i together in IDLE -> COUNT. start_i in COUNT -> counters not cleared. instr_retire_i in the stop cycle -> counted.
